cacheline_rr_arbiter: RTL

- Parametrised N-port arbiter between cacheline requesters (icache, dcache, prefetcher, ...) and the single cacheline port of the memory adapter.
- Generalises the existing two-port icache/dcache arbiter to NUM_PORTS requesters with round-robin fairness.
- Latches the granted request and serialises one transaction at a time.
- Sits between the caches and cache_adapter in cpu.

---
 rtl/cacheline_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cacheline_rr_arbiter.sv
// N-port cacheline arbiter between upstream caches and the single memory-adapter port.
// Round-robin by default; define CACHELINE_ARB_FIXED_PRIO_EN to use fixed lowest-index priority.
module cacheline_rr_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ufp_addr,
  input  logic [NUM_PORTS-1:0]             ufp_read,
  input  logic [NUM_PORTS-1:0]             ufp_write,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  ufp_wdata,
  output logic [LINE_WIDTH-1:0]            ufp_rdata,
  output logic [NUM_PORTS-1:0]             ufp_resp,
  output logic [ADDR_WIDTH-1:0]            dfp_addr,
  output logic                             dfp_read,
  output logic                             dfp_write,
  output logic [LINE_WIDTH-1:0]            dfp_wdata,
  input  logic [LINE_WIDTH-1:0]            dfp_rdata,
  input  logic                             dfp_resp
);

  localparam int GRANT_W = $clog2(NUM_PORTS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [GRANT_W-1:0] LAST_GRANT_RESET = GRANT_W'(NUM_PORTS - 1);

  logic [1:0]            state;
  logic [GRANT_W-1:0]    last_grant;
  logic [NUM_PORTS-1:0]  req;
  logic                  sel_valid;
  logic [GRANT_W-1:0]    sel_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [LINE_WIDTH-1:0] lat_wdata;
  logic                  lat_write;
  logic [LINE_WIDTH-1:0] rdata_q;

  assign req = ufp_read | ufp_write;

`ifdef CACHELINE_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = last_grant;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_valid = 1'b1;
        sel_idx   = GRANT_W'(i);
      end
    end
  end
`else
  // Descending offset scan so the nearest port after last_grant wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = last_grant;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      if (req[(int'(last_grant) + off) % NUM_PORTS]) begin
        sel_valid = 1'b1;
        sel_idx   = GRANT_W'((int'(last_grant) + off) % NUM_PORTS);
      end
    end
  end
`endif

  assign sel_addr  = ufp_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = ufp_wdata[sel_idx*LINE_WIDTH +: LINE_WIDTH];
  assign sel_write = ufp_write[sel_idx];

  assign dfp_addr  = lat_addr;
  assign dfp_wdata = lat_wdata;
  assign ufp_rdata = rdata_q;

  // RESP never arbitrates: the just-served port may still show its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_GRANT_RESET;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
      rdata_q    <= '0;
      dfp_read   <= 1'b0;
      dfp_write  <= 1'b0;
      ufp_resp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_write  <= sel_write;
            last_grant <= sel_idx;
            dfp_write  <= sel_write;
            dfp_read   <= ~sel_write;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (dfp_resp) begin
            if (!lat_write) begin
              rdata_q <= dfp_rdata;
            end
            dfp_read  <= 1'b0;
            dfp_write <= 1'b0;
            ufp_resp  <= NUM_PORTS'(1) << last_grant;
            state     <= RESP;
          end
        end
        RESP: begin
          ufp_resp <= '0;
          state    <= IDLE;
        end
        default: begin
          ufp_resp  <= '0;
          dfp_read  <= 1'b0;
          dfp_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
